// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode encodings, the default target memory
// width and the program-loader state type.
package mips_pkg;

    localparam int unsigned DEF_ADDR_W = 10;

    // Opcode field (bits 31:26) of the pipeline's instruction set.
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b000100;
    localparam logic [5:0] OP_MUL  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    localparam logic [31:0] HALT_WORD_DEF = {OP_HLT, 26'b0};

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_RECV,
        LD_WRITE,
        LD_START,
        LD_DONE
    } ld_state_t;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
//   clk1, rst     : clock, async active-high reset
//   clr           : restart word assembly at byte 0
//   byte_en       : a byte is transferred this cycle
//   byte_data     : the byte (first byte of a word lands in bits 31:24)
//   word_done     : this transfer completes a word (combinational)
//   word          : last completed word, held until the next one completes
//   word_valid    : one-cycle pulse in the cycle after a word completes
module byte_to_word_packer (
    input  logic        clk1,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] part_q;
    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic        valid_q;

    assign word_done  = byte_en && (idx_q == 2'd3);
    assign word       = word_q;
    assign word_valid = valid_q;

    // Partial bytes live apart from word_q so the completed word stays
    // stable while the next one is being received.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            part_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= word_done;
            if (clr) begin
                idx_q <= '0;
            end else if (byte_en) begin
                idx_q  <= idx_q + 2'd1;
                part_q <= {part_q[15:0], byte_data};
                if (idx_q == 2'd3) begin
                    word_q <= {part_q, byte_data};
                end
            end
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// Boot loader: streams a program image byte-wise into the core's memory
// write port, then releases the core to run from PC=0.
//   clk1, rst                 : phase-1 clock, async active-high reset
//   load_req                  : start a load (honoured in IDLE or DONE)
//   in_valid/in_data/in_ready : byte link, transfer = in_valid & in_ready
//   mem_we/mem_addr/mem_wdata : word write port of the target memory
//   cpu_hold, cpu_start       : core halt level and one-cycle start pulse
//   busy, done, err_overflow  : load status (overflow sticky until load_req)
//   word_count                : words written in the current/last load
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic        start_load;
    logic        xfer;
    logic        word_done;
    logic [31:0] word;
    logic        word_valid;

    assign start_load = load_req && ((state_q == LD_IDLE) || (state_q == LD_DONE));
    assign xfer       = in_valid && in_ready;

    byte_to_word_packer u_packer (
        .clk1       (clk1),
        .rst        (rst),
        .clr        (start_load),
        .byte_en    (xfer),
        .byte_data  (in_data),
        .word_done  (word_done),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE, LD_DONE: if (load_req) state_d = LD_RECV;
            LD_RECV:          if (word_done) state_d = LD_WRITE;
            LD_WRITE: begin
                if (word == HALT_WORD)  state_d = LD_START;
                else if (addr_q == '1)  state_d = LD_DONE;
                else                    state_d = LD_RECV;
            end
            LD_START:         state_d = LD_DONE;
            default:          state_d = LD_IDLE;
        endcase
    end

    // Outputs (Moore)
    always_comb begin
        in_ready  = (state_q == LD_RECV);
        mem_we    = (state_q == LD_WRITE) && word_valid;
        busy      = (state_q == LD_RECV) || (state_q == LD_WRITE);
        done      = (state_q == LD_DONE);
        cpu_start = (state_q == LD_START);
        // Core runs from the START cycle on, unless the load overflowed.
        cpu_hold  = !((state_q == LD_START) || ((state_q == LD_DONE) && !err_q));
    end

    // Address, word counter and overflow flag
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (start_load) begin
            addr_d = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
        end else if (state_q == LD_WRITE) begin
            cnt_d = cnt_q + 1'b1;
            if (word != HALT_WORD) begin
                if (addr_q == '1) err_d  = 1'b1;
                else              addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = word;
    assign err_overflow = err_q;
    assign word_count   = cnt_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: a 1024-word instance and a 4-word instance
// driven from byte-level tasks; writes are compared against an expected
// write list derived from the program words.
module tb_mips_prog_loader;

    localparam logic [31:0] HALT = 32'hfc000000;

    typedef struct {
        int          s;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic       clk1 = 1'b0;
    logic       rst;
    logic       ld [2];
    logic       iv [2];
    logic [7:0] id [2];
    logic       rdy [2];
    logic       we [2];
    logic       hold [2];
    logic       cs [2];
    logic       bsy [2];
    logic       dn [2];
    logic       err [2];
    logic [31:0] wd [2];
    logic [9:0]  addr_a;
    logic [1:0]  addr_b;
    logic [10:0] wc_a;
    logic [2:0]  wc_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int starts [2];
    int start_cyc [2];
    int last_we [2];
    wr_t got [$];
    logic [31:0] prog [$];
    logic [31:0] amem [16];

    always #5 clk1 = ~clk1;

    mips_prog_loader #(.ADDR_W(10), .HALT_WORD(32'hfc000000)) dut_a (
        .clk1(clk1), .rst(rst), .load_req(ld[0]), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr_a), .mem_wdata(wd[0]),
        .cpu_hold(hold[0]), .cpu_start(cs[0]), .busy(bsy[0]), .done(dn[0]),
        .err_overflow(err[0]), .word_count(wc_a)
    );

    mips_prog_loader #(.ADDR_W(2), .HALT_WORD(32'hfc000000)) dut_b (
        .clk1(clk1), .rst(rst), .load_req(ld[1]), .in_valid(iv[1]), .in_data(id[1]),
        .in_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr_b), .mem_wdata(wd[1]),
        .cpu_hold(hold[1]), .cpu_start(cs[1]), .busy(bsy[1]), .done(dn[1]),
        .err_overflow(err[1]), .word_count(wc_b)
    );

    function automatic int addr_of(input int s);
        return (s == 1) ? int'(addr_b) : int'(addr_a);
    endfunction

    function automatic int wc_of(input int s);
        return (s == 1) ? int'(wc_b) : int'(wc_a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    // Write monitor plus the ready/write exclusivity rule while busy.
    always @(negedge clk1) begin
        for (int s = 0; s < 2; s++) begin
            if (we[s] === 1'b1) begin
                got.push_back('{s, addr_of(s), wd[s]});
                last_we[s] = cyc;
                if (s == 0 && addr_a < 10'd16) amem[addr_a[3:0]] = wd[0];
            end
            if (cs[s] === 1'b1) begin
                starts[s]++;
                start_cyc[s] = cyc;
            end
            if (bsy[s] === 1'b1) check("in_ready_vs_write", rdy[s], !we[s]);
        end
        cyc++;
    end

    task automatic check_reset(input int s);
        check("rst_in_ready", rdy[s], 0);
        check("rst_mem_we", we[s], 0);
        check("rst_cpu_hold", hold[s], 1);
        check("rst_cpu_start", cs[s], 0);
        check("rst_busy", bsy[s], 0);
        check("rst_done", dn[s], 0);
        check("rst_err", err[s], 0);
        check("rst_word_count", wc_of(s), 0);
        check("rst_mem_addr", addr_of(s), 0);
        check("rst_mem_wdata", wd[s], 0);
    endtask

    task automatic send_byte(input int s, input logic [7:0] b, input bit gaps);
        int n;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 3);
            repeat (g) begin
                iv[s] = 1'b0;
                id[s] = 8'($urandom);
                @(negedge clk1);
            end
        end
        iv[s] = 1'b1;
        id[s] = b;
        n = 0;
        while (!rdy[s] && n < 64) begin
            @(negedge clk1);
            n++;
        end
        check("byte_accept_wait", (n < 64), 1);
        @(negedge clk1);
        iv[s] = 1'b0;
    endtask

    task automatic pulse_load(input int s);
        @(negedge clk1);
        ld[s] = 1'b1;
        @(negedge clk1);
        ld[s] = 1'b0;
    endtask

    // Streams prog[] and checks the resulting writes and final status.
    task automatic run_load(input int s, input bit gaps, input bit mid_req);
        int depth;
        int nexp;
        int k;
        bit started;
        logic [31:0] w;
        depth = (s == 1) ? 4 : 1024;
        got.delete();
        starts[s] = 0;
        pulse_load(s);
        check("load_hold", hold[s], 1);
        check("load_busy", bsy[s], 1);
        check("load_count_clr", wc_of(s), 0);
        check("load_err_clr", err[s], 0);
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            for (int b = 0; b < 4; b++) begin
                if (mid_req && i == 1 && b == 2) begin
                    ld[s] = 1'b1;
                    @(negedge clk1);
                    ld[s] = 1'b0;
                end
                send_byte(s, w[31-8*b -: 8], gaps);
            end
        end
        k = 0;
        while (!dn[s] && k < 20) begin
            @(negedge clk1);
            k++;
        end
        check("done_wait", (k < 20), 1);
        repeat (2) @(negedge clk1);

        nexp = 0;
        started = 0;
        for (int i = 0; i < prog.size(); i++) begin
            nexp++;
            if (prog[i] == HALT) begin
                started = 1;
                break;
            end
            if (i == depth - 1) break;
        end

        check("write_count", got.size(), nexp);
        for (int i = 0; i < nexp && i < got.size(); i++) begin
            check("write_dut", got[i].s, s);
            check("write_addr", got[i].addr, i);
            check("write_data", got[i].data, prog[i]);
        end
        check("word_count", wc_of(s), nexp);
        check("done", dn[s], 1);
        check("busy_end", bsy[s], 0);
        check("err_overflow", err[s], !started);
        check("cpu_hold", hold[s], !started);
        check("start_pulses", starts[s], started ? 1 : 0);
        if (started) check("start_after_write", start_cyc[s], last_we[s] + 1);
        check("addr_held", addr_of(s), nexp - 1);
        check("wdata_held", wd[s], prog[nexp-1]);
    endtask

    task automatic gen_prog(input int n, input bit end_halt);
        logic [31:0] w;
        prog.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == HALT) w = w ^ 32'h1;
            prog.push_back(w);
        end
        if (end_halt) prog[n-1] = HALT;
    endtask

    task automatic load_demo();
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    endtask

    // Minimal instruction-level interpreter over the captured image.
    task automatic run_core();
        int regs [32];
        int pc;
        logic [31:0] ins;
        for (int i = 0; i < 32; i++) regs[i] = 0;
        pc = 0;
        for (int step = 0; step < 64; step++) begin
            ins = amem[pc[3:0]];
            if (ins[31:26] == 6'b111111) break;
            case (ins[31:26])
                6'b000000: regs[ins[15:11]] = regs[ins[25:21]] + regs[ins[20:16]];
                6'b000011: regs[ins[15:11]] = regs[ins[25:21]] | regs[ins[20:16]];
                6'b001010: regs[ins[20:16]] = regs[ins[25:21]] + int'($signed(ins[15:0]));
                default: ;
            endcase
            regs[0] = 0;
            pc++;
        end
        check("core_R1", regs[1], 10);
        check("core_R2", regs[2], 20);
        check("core_R3", regs[3], 25);
        check("core_R4", regs[4], 30);
        check("core_R5", regs[5], 55);
    endtask

    initial begin
        int n;
        for (int s = 0; s < 2; s++) begin
            ld[s] = 1'b0;
            iv[s] = 1'b0;
            id[s] = 8'h00;
            starts[s] = 0;
            start_cyc[s] = 0;
            last_we[s] = 0;
        end
        for (int i = 0; i < 16; i++) amem[i] = 32'hfc000000;
        rst = 1'b1;
        repeat (3) @(negedge clk1);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(negedge clk1);

        // Demo program, continuous stream, then execute the image
        load_demo();
        run_load(0, 0, 0);
        run_core();

        // Same program with random valid gaps
        run_load(0, 1, 0);

        // Reload after completion with a two-word program
        prog = '{32'h28010005, 32'hfc000000};
        run_load(0, 0, 0);

        // Overflow on the 4-word instance
        prog = '{32'h00222000, 32'h00222000, 32'h00222000, 32'h00222000};
        run_load(1, 0, 0);

        // load_req while receiving must be ignored
        load_demo();
        run_load(0, 1, 1);

        // Reset after 6 bytes: async clear, nothing further written
        load_demo();
        got.delete();
        pulse_load(0);
        for (int b = 0; b < 6; b++) begin
            logic [31:0] w;
            w = prog[b/4];
            send_byte(0, w[31-8*(b%4) -: 8], 0);
        end
        #2 rst = 1'b1;
        #1 check_reset(0);
        check_reset(1);
        @(negedge clk1);
        rst = 1'b0;
        repeat (5) @(negedge clk1);
        check("rst_no_more_writes", got.size(), 1);
        prog = '{32'h28010005, 32'hfc000000};
        run_load(0, 0, 0);

        // Randomized programs
        for (int t = 0; t < 3; t++) begin
            n = $urandom_range(1, 12);
            gen_prog(n, 1);
            run_load(0, $urandom_range(0, 1), 0);
        end
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 4);
            gen_prog(n, (n < 4) || ($urandom_range(0, 1) == 1));
            run_load(1, $urandom_range(0, 1), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
Streams a program image into the MIPS pipeline's instruction/data memory over a byte-wide valid/ready link, then releases the core to run. It is the writer side of the memory image that the core's fetch stage reads. It replaces hierarchical memory pre-loading with a synthesizable boot path. It sits between an external byte source (UART RX, JTAG, bench driver) and the core's memory write port and halt/start controls.

Parameters:
ADDR_W, 10, word-address width of the target memory (depth = 2**ADDR_W words)
HALT_WORD, 32'hfc000000, encoding of the HLT instruction; terminates a load

Ports:
clk1  input  1  core phase-1 clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
load_req  input  1  one-cycle request to start a new load; ignored unless state is IDLE or DONE
in_valid  input  1  byte source has a valid byte
in_data  input  8  program byte; big-endian within each word (first byte = bits 31:24)
in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
mem_we  output  1  memory write strobe, one cycle per word
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  assembled instruction word
cpu_hold  output  1  keeps the core halted (drives HALTED/PC clear); high while not running
cpu_start  output  1  one-cycle pulse: core starts fetching at PC=0
busy  output  1  load in progress (RECV or WRITE)
done  output  1  load finished (DONE state)
err_overflow  output  1  memory filled without HALT_WORD; sticky until next load_req
word_count  output  ADDR_W+1  number of words written in the current/last load

Behaviour:
- Reset (async, any state): state=IDLE; cpu_hold=1; in_ready=0; mem_we=0; cpu_start=0; busy=0; done=0; err_overflow=0; word_count=0; mem_addr=0; mem_wdata=0; byte index=0.
- States: IDLE, RECV, WRITE, START, DONE.
- IDLE: cpu_hold=1. load_req -> RECV; clears word_count, mem_addr, err_overflow, byte index.
- RECV: in_ready=1, busy=1. Each transfer shifts in_data into the word buffer MSB-first. The byte index wraps 0..3. The 4th byte -> WRITE next cycle. in_valid low: wait indefinitely, no timeout.
- WRITE (exactly 1 cycle): in_ready=0; mem_we=1 with mem_addr and the completed word on mem_wdata; word_count increments.
  - Word == HALT_WORD -> START. The HLT word is itself written.
  - Else if mem_addr == 2**ADDR_W-1 -> set err_overflow, go to DONE. cpu_hold stays 1 and the core is not started.
  - Else mem_addr increments -> RECV.
- Latency: last byte accepted at edge N -> mem_we high during cycle N+1. Throughput is at most 4 bytes per 5 cycles.
- START (1 cycle): cpu_start=1; cpu_hold falls to 0 at the same edge -> DONE.
- DONE: done=1. cpu_hold=0 if started, 1 if err_overflow. load_req -> IDLE-equivalent restart:
  - cpu_hold=1 from the next edge, so the core is frozen before any memory write;
  - counters cleared;
  - go to RECV.
- load_req during RECV/WRITE/START: ignored, no effect.
- Bytes offered while in_ready=0: not consumed; the source must hold them.
- Partial word when reset asserts: discarded, nothing written.
- mem_wdata and mem_addr hold their last value when mem_we=0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants, including HLT, from which HALT_WORD = {HLT, 26'b0};
  - the loader state enum;
  - the default memory address width.
- Natural sub-module: byte_to_word_packer. It holds the shift register, the byte index and the word_valid pulse; the FSM owns addresses and core control.

Test Plan:
- Reset then load_req. Stream the 9-word program 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 with in_valid always high.
  - Required: 9 mem_we pulses at addr 0..8 with those words; word_count=9; cpu_start pulse one cycle after the final write; cpu_hold=0; done=1.
  - Core then ends with R1=10, R2=20, R3=25, R4=30, R5=55.
- Same stream with random in_valid gaps. Required: identical writes and ordering; in_ready=0 exactly in each WRITE cycle.
- ADDR_W=2 with 4 non-HLT words (00222000 x4).
  - Required: writes at addr 0..3; err_overflow=1; done=1; cpu_hold=1; no cpu_start.
- After a completed load, load_req then 2 words (28010005, fc000000).
  - Required: cpu_hold=1 on the next edge; writes at addr 0,1; word_count=2; fresh cpu_start pulse.
- Assert rst after 6 bytes of a load. Required: all outputs at reset values immediately (asynchronous); no further mem_we; the next load starts at addr 0 with byte index 0.
- load_req pulsed mid-RECV. Required: ignored; addresses and word_count continue uninterrupted.
